// File: rtl/PARAMS_pkg.sv
// Shared constants and the instruction-queue entry type for the fetch front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package PARAMS_pkg;

    localparam int INSTR_SIZE = 32;

    // Boot vector used as the default reset PC.
    localparam logic [INSTR_SIZE-1:0] BOOT_ADDR = 32'h0000_0000;

    // Instruction presented to decode whenever the queue head is not valid (addi x0,x0,0).
    localparam logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

    // One queue slot: the fetched word together with the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_SIZE-1:0] instr;
        logic [INSTR_SIZE-1:0] pc;
    } queue_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic circular FIFO with flush and occupancy count; head is read straight from storage.
// Latency: a push at edge N is visible on head_o after edge N (no write-to-read bypass).
// Backpressure: push is ignored when full unless a pop occurs in the same cycle; pop is ignored when empty.
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = logic [63:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  ENTRY_T                   push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output ENTRY_T                   head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    // DEPTH is a power of two, so the pointers wrap for free.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ENTRY_T          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; flush empties the queue and wins over push/pop.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch: issues in-order fetches and queues returned words with their PC for decode.
// Latency: a response is visible on instr/instr_valid one cycle after it is accepted (no bypass).
// Backpressure: requests are credit-limited so queued + in-flight never exceeds QUEUE_DEPTH; decode stalls via instr_ready.
module fetch_prefetch_unit #(
    parameter int                    INSTR_SIZE  = PARAMS_pkg::INSTR_SIZE,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [INSTR_SIZE-1:0] RESET_PC    = INSTR_SIZE'(PARAMS_pkg::BOOT_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jump_valid,
    input  logic [INSTR_SIZE-1:0] pc_jump,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [INSTR_SIZE-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_SIZE-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [INSTR_SIZE-1:0] pc_actual
);

    // INSTR_SIZE must match the package width, since queue entries use the package struct.
    // QUEUE_DEPTH must be a power of two and at least 2.
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    typedef PARAMS_pkg::queue_entry_t entry_t;

    logic [INSTR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [INSTR_SIZE-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW:0]           credit_sum;
    logic                  req_fire;
    logic                  q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]         q_count;
    entry_t                q_push_dat, q_head;

    // Every in-flight request owns a queue slot, so a response can always be pushed.
    assign credit_sum     = {1'b0, q_count} + {1'b0, outstanding_q};
    assign imem_req_valid = !reset && !jump_valid && !q_full
                            && (credit_sum < (CW+1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // The head is hidden during a redirect cycle because the queue is about to be flushed.
    assign instr_valid = !q_empty && !jump_valid;
    assign q_pop       = instr_valid && instr_ready;
    assign instr       = instr_valid ? q_head.instr : PARAMS_pkg::NOP_INSTR;
    assign pc_actual   = instr_valid ? q_head.pc : rsp_pc_q;

    // Next-state for PCs, in-flight count, stale-response count and queue push.
    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        rsp_pc_d         = rsp_pc_q;
        outstanding_d    = outstanding_q;
        drop_d           = drop_q;
        q_push           = 1'b0;
        q_push_dat.instr = imem_rsp_data;
        q_push_dat.pc    = rsp_pc_q;

        case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + INSTR_SIZE'(4);
        end

        if (jump_valid) begin
            // No request fires in a jump cycle, so everything still in flight is stale,
            // including requests already marked for dropping by an earlier jump.
            fetch_pc_d = pc_jump;
            rsp_pc_d   = pc_jump;
            drop_d     = outstanding_d;
        end else if (imem_rsp_valid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                q_push   = 1'b1;
                rsp_pc_d = rsp_pc_q + INSTR_SIZE'(4);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .ENTRY_T (entry_t)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (q_push),
        .push_dat_i (q_push_dat),
        .pop_i      (q_pop),
        .flush_i    (jump_valid),
        .head_o     (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

endmodule
